// File: rtl/fifo_rd_pkg.sv
// Shared constants and the issue-credit helper for the FIFO read-side streamer.
package fifo_rd_pkg;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned PTR_W     = 1;

  // A new read may issue only while the words already committed to the buffer
  // (stored, minus the one leaving this cycle, plus the one in flight) leave room.
  function automatic logic can_issue(input logic [1:0] occ,
                                     input logic       pop,
                                     input logic       inflight);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (committed < 3'(BUF_DEPTH));
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry circular buffer holding words captured from the FIFO read port.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head_data
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t            mem_q [BUF_DEPTH];
  beat_t            mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      mem_d[tail_q].data = push_data;
      tail_d             = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[head_q].data;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for a latency-1 FIFO: issues rd_en under credit control and
// presents the captured words as a valid/ready stream with optional framing.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  word_count,
  output logic              busy
);

  localparam int unsigned      IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((PKT_LEN > 0) ? PKT_LEN - 1 : 0);
  localparam logic             FRAMING  = (PKT_LEN != 0);

  logic [1:0]       occ;
  logic             pop;
  logic             inflight_q, inflight_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign m_valid    = (occ != 2'd0);
  assign pop        = m_valid & m_ready;
  assign fifo_rd_en = enable & ~fifo_empty & ~rst & can_issue(occ, pop, inflight_q);

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  always_comb begin
    inflight_d = fifo_rd_en;
    cnt_d      = cnt_q + CNT_W'(pop);
    idx_d      = idx_q;
    if (!FRAMING) begin
      idx_d = '0;
    end else if (pop) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m_last     = FRAMING & m_valid & (idx_q == LAST_IDX);
  assign word_count = cnt_q;
  assign busy       = m_valid | inflight_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural latency-1 FIFO, scoreboard of
// expected beats, and a second instance with CNT_W=4 / PKT_LEN=0 on shared inputs.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst, enable, fifo_empty, m_ready;
  logic [31:0] fifo_dout;

  logic        rd_en, m_valid, m_last, busy;
  logic [31:0] m_data;
  logic [15:0] wc;
  logic        rd_en2, m_valid2, m_last2, busy2;
  logic [31:0] m_data2;
  logic [3:0]  wc2;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_W(32), .PKT_LEN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en), .fifo_dout(fifo_dout), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .word_count(wc), .busy(busy)
  );

  fifo_rd_stream #(.DATA_W(32), .PKT_LEN(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en2), .fifo_dout(fifo_dout), .m_valid(m_valid2),
    .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2),
    .word_count(wc2), .busy(busy2)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fq[$];
  logic [31:0] sb[$];
  logic [31:0] last_q[$];
  bit          chk_en = 1'b0;
  int          occ_m = 0, inflight_m = 0, idx_m = 0, acc = 0, cyc = 0;
  int          rd_cnt, pop_cnt, last_cnt, first_rd, first_v, first_last_beat;
  logic        s_valid, s_busy, s_last;
  logic [31:0] s_data;
  logic [15:0] s_wc;
  logic [3:0]  s_wc2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; pop_cnt = 0; last_cnt = 0;
    first_rd = -1; first_v = -1; first_last_beat = -1;
    last_q.delete();
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 32'(i));
      sb.push_back(base + 32'(i));
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // One clock: sample at negedge, then advance the FIFO and reference model.
  task automatic step();
    logic rd, pop;
    int   outst;
    @(negedge clk);
    rd  = rd_en;
    pop = m_valid && m_ready && !rst;
    s_valid = m_valid; s_busy = busy; s_data = m_data; s_last = m_last;
    s_wc = wc; s_wc2 = wc2;
    if (chk_en) begin
      chk("rd_while_empty", {31'd0, rd & fifo_empty}, 32'd0);
      if (rst) chk("rd_in_reset", {31'd0, rd}, 32'd0);
      chk("m_valid", {31'd0, m_valid}, {31'd0, occ_m != 0});
      chk("busy", {31'd0, busy}, {31'd0, (occ_m != 0) || (inflight_m != 0)});
      outst = occ_m + inflight_m;
      if (rd) chk("credit", {31'd0, (outst - int'(pop)) < 2}, 32'd1);
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk("valid_without_data", {31'd0, m_valid}, 32'd0);
        end else begin
          chk("m_data", m_data, sb[0]);
          chk("m_data_w4", m_data2, sb[0]);
        end
        chk("m_last", {31'd0, m_last}, {31'd0, idx_m == 3});
      end
      chk("m_last_noframe", {31'd0, m_last2}, 32'd0);
      chk("word_count", {16'd0, wc}, 32'(acc % 65536));
      chk("word_count_w4", {28'd0, wc2}, 32'(acc % 16));
    end
    if (rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && !rst && first_v < 0) first_v = cyc;
    if (pop) begin
      pop_cnt++;
      if (m_last) begin
        last_cnt++;
        last_q.push_back(m_data);
        if (first_last_beat < 0) first_last_beat = pop_cnt;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < occ_m + inflight_m; i++) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end
      occ_m = 0; inflight_m = 0; idx_m = 0; acc = 0;
    end else begin
      occ_m      = occ_m + inflight_m - int'(pop);
      inflight_m = int'(rd);
      if (pop) begin
        if (sb.size() > 0) void'(sb.pop_front());
        acc++;
        idx_m = (idx_m == 3) ? 0 : idx_m + 1;
      end
    end
    if (rd && fq.size() > 0) fifo_dout = fq.pop_front();
    else                     fifo_dout = $urandom();
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    repeat (3) step();
    chk_en = 1'b1;
    step();
    chk("rst_m_data", s_data, 32'd0);
    chk("rst_m_last", {31'd0, s_last}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    rst = 1'b0;
    step();

    // Full throughput, 8 beats.
    clear_stats();
    load(32'hA0, 8);
    enable = 1'b1; m_ready = 1'b1;
    repeat (8) step();
    chk("t1_rd_8_cycles", 32'(rd_cnt), 32'd8);
    repeat (4) step();
    chk("t1_latency", 32'(first_v - first_rd), 32'd2);
    chk("t1_pops", 32'(pop_cnt), 32'd8);
    chk("t1_lasts", 32'(last_cnt), 32'd2);
    if (last_q.size() == 2) begin
      chk("t1_last0", last_q[0], 32'hA3);
      chk("t1_last1", last_q[1], 32'hA7);
    end else begin
      chk("t1_last_count", 32'(last_q.size()), 32'd2);
    end
    chk("t1_wc", {16'd0, s_wc}, 32'd8);

    // Toggling backpressure.
    clear_stats();
    load(32'hA0, 8);
    for (int i = 0; i < 24; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    m_ready = 1'b1;
    repeat (3) step();
    chk("t2_pops", 32'(pop_cnt), 32'd8);
    chk("t2_sb_drained", 32'(sb.size()), 32'd0);

    // Stall with 5 words queued.
    clear_stats();
    m_ready = 1'b0;
    load(32'hB0, 5);
    repeat (6) step();
    chk("t3_rd_pulses", 32'(rd_cnt), 32'd2);
    chk("t3_rd_held", {31'd0, rd_en}, 32'd0);
    m_ready = 1'b1;
    repeat (10) step();
    chk("t3_pops", 32'(pop_cnt), 32'd5);
    chk("t3_sb_drained", 32'(sb.size()), 32'd0);

    // enable dropped after the third read.
    clear_stats();
    load(32'hC0, 6);
    for (int i = 0; i < 20; i++) begin
      if (rd_cnt >= 3) break;
      step();
    end
    chk("t4_reach_3_reads", 32'(rd_cnt), 32'd3);
    enable = 1'b0;
    repeat (8) step();
    chk("t4_reads", 32'(rd_cnt), 32'd3);
    chk("t4_pops", 32'(pop_cnt), 32'd3);
    chk("t4_busy_idle", {31'd0, s_busy}, 32'd0);
    enable = 1'b1;
    repeat (8) step();
    chk("t4_sb_drained", 32'(sb.size()), 32'd0);

    // Reset mid-transfer with two words outstanding.
    clear_stats();
    m_ready = 1'b0;
    load(32'hD0, 4);
    repeat (2) step();
    chk("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; enable = 1'b0;
    step();
    chk("t5_valid_post", {31'd0, s_valid}, 32'd0);
    chk("t5_wc_post", {16'd0, s_wc}, 32'd0);
    chk("t5_busy_post", {31'd0, s_busy}, 32'd0);
    clear_stats();
    load(32'hD4, 4);
    enable = 1'b1; m_ready = 1'b1;
    repeat (12) step();
    chk("t5_first_last_beat", 32'(first_last_beat), 32'd4);
    chk("t5_pops", 32'(pop_cnt), 32'd6);

    // Counter wrap on the 4-bit instance: 17 beats since reset.
    load(32'hE0, 11);
    repeat (16) step();
    chk("t6_wc16", {16'd0, s_wc}, 32'd17);
    chk("t6_wc4_wrapped", {28'd0, s_wc2}, 32'd1);
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
